// File: rtl/exec_trace_buffer_pkg.sv
// Shared definitions for the execution trace buffer: FSM encodings, default widths and record layout.
// Benches and downstream bridges decode rd_data_o with the field offsets below.
package exec_trace_buffer_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int PC_W_DEF    = 4;
    localparam int INSTR_W_DEF = 8;
    localparam int DATA_W_DEF  = 4;
    localparam int STAMP_W_DEF = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Field LSB offsets for the default configuration, r0 at bit 0.
    localparam int R0_LSB    = 0;
    localparam int R1_LSB    = R0_LSB + DATA_W_DEF;
    localparam int R2_LSB    = R1_LSB + DATA_W_DEF;
    localparam int R3_LSB    = R2_LSB + DATA_W_DEF;
    localparam int HALT_BIT  = R3_LSB + DATA_W_DEF;
    localparam int INSTR_LSB = HALT_BIT + 1;
    localparam int PC_LSB    = INSTR_LSB + INSTR_W_DEF;
    localparam int STAMP_LSB = PC_LSB + PC_W_DEF;

    typedef struct packed {
        logic [STAMP_W_DEF-1:0] stamp;
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
        logic                   halt;
        logic [DATA_W_DEF-1:0]  r3;
        logic [DATA_W_DEF-1:0]  r2;
        logic [DATA_W_DEF-1:0]  r1;
        logic [DATA_W_DEF-1:0]  r0;
    } trace_rec_t;

    function automatic int rec_width(input int stamp_w, input int pc_w,
                                     input int instr_w, input int data_w);
        return stamp_w + pc_w + instr_w + 1 + 4 * data_w;
    endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular record store: push overwrites the oldest entry when full, pop retires the oldest.
// Read port is asynchronous on the read pointer; clear resets pointers and count only.
module trace_ring #(
    parameter int DEPTH = 16,
    parameter int W     = 37,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            // When full the oldest slot is the one being overwritten, so the read side follows.
            if (full_o) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_i && (count_q != '0)) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/exec_trace_buffer.sv
// Captures one cpu state record per clock into a ring until halt or cap_en drop, then drains
// oldest-first over valid/ready. Zero-latency async read; rd_data held stable while stalled.
module exec_trace_buffer
    import exec_trace_buffer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STAMP_W = STAMP_W_DEF,
    parameter int REC_W   = STAMP_W + PC_W + INSTR_W + 1 + 4 * DATA_W,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cap_en_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               halt_i,
    input  logic [DATA_W-1:0]  r0_i,
    input  logic [DATA_W-1:0]  r1_i,
    input  logic [DATA_W-1:0]  r2_i,
    input  logic [DATA_W-1:0]  r3_i,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [REC_W-1:0]   rd_data_o,
    output logic               rd_last_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               overflow_o,
    output logic               busy_o
);

    logic [1:0]         state_q, state_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic               overflow_q, overflow_d;
    logic               push, pop, clr;
    logic               full;
    logic [CNT_W-1:0]   cnt;
    logic [REC_W-1:0]   wr_rec, ring_rdata;

    assign wr_rec = {stamp_q, pc_i, instr_i, halt_i, r3_i, r2_i, r1_i, r0_i};

    trace_ring #(
        .DEPTH (DEPTH),
        .W     (REC_W),
        .PTR_W ($clog2(DEPTH)),
        .CNT_W (CNT_W)
    ) u_ring (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr),
        .push_i  (push),
        .wdata_i (wr_rec),
        .pop_i   (pop),
        .rdata_o (ring_rdata),
        .count_o (cnt),
        .full_o  (full)
    );

    assign rd_valid_o = (state_q == ST_DRAIN) && (cnt != '0);
    assign rd_data_o  = rd_valid_o ? ring_rdata : '0;
    assign rd_last_o  = rd_valid_o && (cnt == CNT_W'(1));
    assign count_o    = cnt;
    assign overflow_o = overflow_q;
    assign busy_o     = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        stamp_d    = stamp_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;
        clr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cap_en_i) begin
                    state_d    = ST_CAPTURE;
                    stamp_d    = '0;
                    overflow_d = 1'b0;
                    clr        = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // halt wins over cap_en drop: the halting cycle is always recorded.
                if (halt_i || cap_en_i) begin
                    push = 1'b1;
                    if (full) overflow_d = 1'b1;
                    if (stamp_q != '1) stamp_d = stamp_q + 1'b1;
                    if (halt_i) state_d = ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pop = rd_valid_o && rd_ready_i;
                if ((cnt == '0) || (pop && (cnt == CNT_W'(1)))) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!cap_en_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            stamp_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stamp_q    <= stamp_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
